// File: rtl/uart_msg_scheduler.sv
// Round-robin scheduler feeding uart_tx: holds one pending message per source and
// serialises it byte-by-byte with a fixed per-byte slot so each frame completes.
`timescale 1ns/1ps
module uart_msg_scheduler #(
  parameter int NUM_REQ     = 3,
  parameter int MAX_BYTES   = 8,
  parameter int BYTE_CYCLES = 4340
) (
  input  logic               clk_50M,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [63:0]        msg0,
  input  logic [63:0]        msg1,
  input  logic [63:0]        msg2,
  input  logic [3:0]         len0,
  input  logic [3:0]         len1,
  input  logic [3:0]         len2,
  output logic [NUM_REQ-1:0] ack,
  output logic               busy,
  output logic [7:0]         tx_byte,
  output logic               data_send,
  output logic [NUM_REQ-1:0] overflow
);

  localparam int GAP_W = $clog2(BYTE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [63:0]        r_slot [NUM_REQ];
  logic [3:0]         r_len [NUM_REQ];
  logic [NUM_REQ-1:0] r_pending;
  logic [NUM_REQ-1:0] r_overflow;
  logic [1:0]         r_rrPtr;
  logic [1:0]         r_grant;
  logic [2:0]         r_byteCnt;
  logic [GAP_W-1:0]   r_gap;
  logic [7:0]         r_txByte;

  logic [63:0]        w_msgIn [NUM_REQ];
  logic [3:0]         w_lenIn [NUM_REQ];
  logic [1:0]         w_cand1;
  logic [1:0]         w_cand2;
  logic [1:0]         w_grantIdx;
  logic               w_anyPending;
  logic               w_moreBytes;
  logic               w_gapNext;
  logic               w_gapLast;

  function automatic logic [1:0] incIdx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  function automatic logic [7:0] pickByte(input logic [63:0] msg, input logic [2:0] idx);
    logic [63:0] shifted;
    shifted = msg << {idx, 3'b000};
    return shifted[63:56];
  endfunction

  function automatic logic [3:0] clampLen(input logic [3:0] len);
    return (len > 4'(MAX_BYTES)) ? 4'(MAX_BYTES) : len;
  endfunction

  assign w_msgIn[0] = msg0;
  assign w_msgIn[1] = msg1;
  assign w_msgIn[2] = msg2;
  assign w_lenIn[0] = len0;
  assign w_lenIn[1] = len1;
  assign w_lenIn[2] = len2;

  assign w_cand1      = incIdx(r_rrPtr);
  assign w_cand2      = incIdx(w_cand1);
  assign w_anyPending = |r_pending;
  assign w_moreBytes  = ({1'b0, r_byteCnt} + 4'd1) < r_len[r_grant];
  assign w_gapNext    = (r_gap == GAP_W'(BYTE_CYCLES - 2));
  // The last byte keeps its slot one cycle longer so its stop bit has cleared before ack.
  assign w_gapLast    = (r_gap == GAP_W'(BYTE_CYCLES - 1));

  always_comb begin
    w_grantIdx = w_cand2;
    if (r_pending[r_rrPtr]) begin
      w_grantIdx = r_rrPtr;
    end else if (r_pending[w_cand1]) begin
      w_grantIdx = w_cand1;
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    data_send   = 1'b0;
    busy        = 1'b0;
    ack         = '0;
    case (r_state)
      IDLE: begin
        if (w_anyPending) begin
          w_nextState = SEND;
        end
      end
      SEND: begin
        data_send   = 1'b1;
        busy        = 1'b1;
        w_nextState = GAP;
      end
      GAP: begin
        busy = 1'b1;
        if (w_moreBytes && w_gapNext) begin
          w_nextState = SEND;
        end else if (!w_moreBytes && w_gapLast) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        ack         = NUM_REQ'(1) << r_grant;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_slot[i] <= '0;
        r_len[i]  <= '0;
      end
      r_pending  <= '0;
      r_overflow <= '0;
      r_rrPtr    <= '0;
      r_grant    <= '0;
      r_byteCnt  <= '0;
      r_gap      <= '0;
      r_txByte   <= '0;
    end else begin
      // A slot being acked this cycle counts as free, so a colliding request is latched.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req[i] && (w_lenIn[i] != 4'd0)) begin
          if (!r_pending[i] || ack[i]) begin
            r_slot[i]    <= w_msgIn[i];
            r_len[i]     <= clampLen(w_lenIn[i]);
            r_pending[i] <= 1'b1;
          end else begin
            r_overflow[i] <= 1'b1;
          end
        end else if (ack[i]) begin
          r_pending[i] <= 1'b0;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_anyPending) begin
            r_grant   <= w_grantIdx;
            r_byteCnt <= '0;
            r_txByte  <= pickByte(r_slot[w_grantIdx], 3'd0);
          end
        end
        SEND: r_gap <= '0;
        GAP: begin
          r_gap <= r_gap + GAP_W'(1);
          if (w_moreBytes && w_gapNext) begin
            r_byteCnt <= r_byteCnt + 3'd1;
            r_txByte  <= pickByte(r_slot[r_grant], r_byteCnt + 3'd1);
          end
        end
        DONE: r_rrPtr <= incIdx(r_grant);
        default: ;
      endcase
    end
  end

  assign tx_byte  = r_txByte;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_msg_scheduler.sv
// Scoreboard bench for uart_msg_scheduler: stimulus pushes expected bytes/acks with
// their cycle numbers; a negedge monitor pops and compares each DUT strobe.
`timescale 1ns/1ps
module tb_uart_msg_scheduler;

  localparam int B = 16;

  logic        clk_50M = 1'b0;
  logic        rst_n   = 1'b0;
  logic [2:0]  req     = '0;
  logic [63:0] msg0    = '0;
  logic [63:0] msg1    = '0;
  logic [63:0] msg2    = '0;
  logic [3:0]  len0    = '0;
  logic [3:0]  len1    = '0;
  logic [3:0]  len2    = '0;
  logic [2:0]  ack;
  logic [2:0]  overflow;
  logic        busy;
  logic        data_send;
  logic [7:0]  tx_byte;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         isAck;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  uart_msg_scheduler #(
    .NUM_REQ    (3),
    .MAX_BYTES  (8),
    .BYTE_CYCLES(B)
  ) dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .req      (req),
    .msg0     (msg0),
    .msg1     (msg1),
    .msg2     (msg2),
    .len0     (len0),
    .len1     (len1),
    .len2     (len2),
    .ack      (ack),
    .busy     (busy),
    .tx_byte  (tx_byte),
    .data_send(data_send),
    .overflow (overflow)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  // Tuple layout {kind, value, cycle}: kind 0 = data_send byte, 1 = ack one-hot.
  always @(negedge clk_50M) begin
    if (rst_n && (data_send || (ack != 3'b000))) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_strobe", {16'h0, 8'(!data_send), (data_send ? tx_byte : {5'b0, ack}), 32'(cyc)}, 64'h0);
      end else begin
        monE = expQ.pop_front();
        checkOutput(monE.isAck ? "ack" : "send",
                    {16'h0, 8'(!data_send), (data_send ? tx_byte : {5'b0, ack}), 32'(cyc)},
                    {16'h0, 8'(monE.isAck), monE.val, 32'(monE.cyc)});
      end
    end
  end

  initial begin
    #(20 * 20000);
    $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic gotoCycle(input int c);
    while (cyc < c) begin
      @(posedge clk_50M);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input logic [3:0] l0, input logic [3:0] l1,
                               input logic [3:0] l2, output int p);
    len0 = l0;
    len1 = l1;
    len2 = l2;
    req  = mask;
    p    = cyc;
    @(posedge clk_50M);
    #1;
    req = '0;
  endtask

  task automatic expectMsg(input int idx, input logic [63:0] m, input int n, input int firstSend,
                           output int ackCyc);
    logic [63:0] shifted;
    exp_t e;
    for (int k = 0; k < n; k++) begin
      shifted = m << (8 * k);
      e = '{1'b0, shifted[63:56], firstSend + k * B};
      expQ.push_back(e);
    end
    ackCyc = firstSend + n * B + 1;
    e = '{1'b1, 8'(1 << idx), ackCyc};
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < limit) begin
      @(posedge clk_50M);
      #1;
      n++;
    end
    checkOutput(name, 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_data_send"}, 64'(data_send), 64'd0);
    checkOutput({tag, "_busy"},      64'(busy),      64'd0);
    checkOutput({tag, "_ack"},       64'(ack),       64'd0);
    checkOutput({tag, "_overflow"},  64'(overflow),  64'd0);
    checkOutput({tag, "_tx_byte"},   64'(tx_byte),   64'd0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
  endtask

  initial begin
    int p;
    int a;
    int a2;
    int a3;
    exp_t e;

    idle(2);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single message, 3 bytes");
    msg0 = 64'h4142_4300_0000_0000;
    applyStimulus(3'b001, 4'd3, 4'd0, 4'd0, p);
    expectMsg(0, msg0, 3, p + 2, a);
    waitDrain("single_drain", 5 * B);
    checkOutput("single_busy_after", 64'(busy), 64'd0);
    checkOutput("single_tx_hold", 64'(tx_byte), 64'h43);

    $display("[TB] round-robin");
    doReset();
    msg0 = 64'hA0A1_0000_0000_0000;
    msg1 = 64'hB1B2_0000_0000_0000;
    msg2 = 64'hC2C3_0000_0000_0000;
    applyStimulus(3'b111, 4'd1, 4'd1, 4'd1, p);
    expectMsg(0, msg0, 1, p + 2, a);
    expectMsg(1, msg1, 1, a + 2, a);
    expectMsg(2, msg2, 1, a + 2, a);
    waitDrain("rr1_drain", 10 * B);
    msg0 = 64'hD3D4_0000_0000_0000;
    msg2 = 64'hE4E5_0000_0000_0000;
    applyStimulus(3'b101, 4'd1, 4'd1, 4'd1, p);
    expectMsg(0, msg0, 1, p + 2, a);
    expectMsg(2, msg2, 1, a + 2, a);
    waitDrain("rr2_drain", 8 * B);

    $display("[TB] overflow on slot 1");
    msg1 = 64'h1122_0000_0000_0000;
    applyStimulus(3'b010, 4'd0, 4'd2, 4'd0, p);
    expectMsg(1, msg1, 2, p + 2, a);
    idle(1);
    applyStimulus(3'b010, 4'd0, 4'd2, 4'd0, a2);
    idle(2);
    applyStimulus(3'b010, 4'd0, 4'd3, 4'd0, a2);
    waitDrain("ovf_drain", 6 * B);
    idle(2 * B);
    checkOutput("ovf_flags", 64'(overflow), 64'b010);

    $display("[TB] length edges");
    applyStimulus(3'b001, 4'd0, 4'd0, 4'd0, p);
    idle(3 * B);
    checkOutput("len0_busy", 64'(busy), 64'd0);
    msg0 = 64'h0102_0304_0506_0708;
    applyStimulus(3'b001, 4'd12, 4'd0, 4'd0, p);
    expectMsg(0, msg0, 8, p + 2, a);
    waitDrain("len12_drain", 12 * B);
    checkOutput("len12_last_byte", 64'(tx_byte), 64'h08);

    $display("[TB] reset mid-message");
    msg2 = 64'h5152_5354_5500_0000;
    applyStimulus(3'b100, 4'd0, 4'd0, 4'd5, p);
    e = '{1'b0, 8'h51, p + 2};
    expQ.push_back(e);
    e = '{1'b0, 8'h52, p + 2 + B};
    expQ.push_back(e);
    gotoCycle(p + 2 + B + 3);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    idle(2);
    rst_n = 1'b1;
    idle(3 * B);
    checkOutput("midreset_busy_after", 64'(busy), 64'd0);
    checkOutput("midreset_sent_bytes", 64'(expQ.size()), 64'd0);
    expQ.delete();

    $display("[TB] ack/req collision");
    msg0 = 64'h6100_0000_0000_0000;
    msg1 = 64'h7200_0000_0000_0000;
    applyStimulus(3'b011, 4'd1, 4'd1, 4'd0, p);
    expectMsg(0, msg0, 1, p + 2, a);
    gotoCycle(a);
    msg0 = 64'h6300_0000_0000_0000;
    applyStimulus(3'b001, 4'd1, 4'd0, 4'd0, a2);
    expectMsg(1, msg1, 1, a + 2, a2);
    expectMsg(0, 64'h6300_0000_0000_0000, 1, a2 + 2, a3);
    waitDrain("collide_drain", 8 * B);
    checkOutput("collide_overflow", 64'(overflow), 64'd0);

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_msg_scheduler.md
Name: uart_msg_scheduler

Overview:
- Arbitrates between up to three message sources for the single uart_tx byte transmitter. The sources are the fault report, the block-pickup report and the end-of-run report.
- Holds one pending message per source, serialises each message byte-by-byte into uart_tx's data/data_send handshake, and paces bytes so that each transmitted frame completes before the next byte is issued.
- Sits between the message-generating units and uart_tx, in the clk_50M domain.

Parameters:
- NUM_REQ, 3, number of requester slots (fixed 3 in this revision).
- MAX_BYTES, 8, maximum message length in bytes.
- BYTE_CYCLES, 4340, clk_50M cycles reserved per byte (10 bits at 115200 baud, 434 cycles/bit); minimum legal value 2.

Ports:
- clk_50M  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- req  in  3  per-source single-cycle request strobe.
- msg0  in  64  source 0 message; byte 0 = msg0[63:56], sent first.
- msg1  in  64  source 1 message, same byte order.
- msg2  in  64  source 2 message, same byte order.
- len0  in  4  source 0 length in bytes, sampled with req[0].
- len1  in  4  source 1 length, sampled with req[1].
- len2  in  4  source 2 length, sampled with req[2].
- ack  out  3  one-cycle pulse on index i when source i's message has fully transmitted.
- busy  out  1  high while a message is being serialised.
- tx_byte  out  8  byte presented to uart_tx data.
- data_send  out  1  one-cycle strobe to uart_tx.
- overflow  out  3  sticky per-source flag: a request arrived while that slot was pending.

Behaviour:
- Reset (async assert, sync release): all outputs 0; pending[2:0]=0; round-robin pointer=0; FSM=IDLE. Asserting rst_n low mid-message aborts immediately: no further data_send, and no ack for the aborted message.
- Slot latch: when req[i]=1 and pending[i]=0, on the next edge msg_i and len_i are copied to slot i and pending[i] is set.
  - len 0: request ignored; no pending, no ack.
  - len >8: clamped to 8.
- Slot occupied: when req[i]=1 and pending[i]=1, the request is dropped and overflow[i] is set. The bit stays set until reset.
- Same-cycle ack and req: if ack[i] fires in the same cycle as req[i], the slot is treated as free and the new request is latched (no overflow).
- FSM states:
  - IDLE: if any pending bit is set, grant the first pending index at or after rr_ptr (wrapping 2→0). Load byte counter=0 and go to SEND. busy goes high on this transition.
  - SEND: tx_byte = slot[grant] byte[counter]; data_send=1 for exactly this cycle; clear gap counter; go to GAP.
  - GAP: count to BYTE_CYCLES-1.
    - If counter+1 < len: increment counter and go to SEND.
    - Otherwise go to DONE.
  - DONE: ack[grant]=1 for one cycle; clear pending[grant]; rr_ptr = grant+1 mod 3; busy=0; go to IDLE.
- tx_byte holds its value from SEND through the end of GAP. tx_byte is not cleared in IDLE.
- Latency:
  - req at edge t → pending at t+1 → SEND at t+2. The first data_send is visible in the cycle after the IDLE grant.
  - Spacing between consecutive data_send strobes within a message is exactly BYTE_CYCLES cycles.
  - A message of N bytes ends with ack N·BYTE_CYCLES+1 cycles after its first data_send.
  - The next granted message's first data_send follows ack by 2 cycles.
- Pending requests arriving during a transmission are queued in their slot and never preempt the message in flight.

Test Plan:
- Single message: req[0] pulse, len0=3, msg0=0x41_42_43_xx… → data_send at cycles +2, +2+4340, +2+8680 with tx_byte 0x41, 0x42, 0x43; ack[0] one pulse at +2+13021; busy low afterwards.
- Round-robin: req[2:0]=3'b111 together, all len=1 → grant order 0, 1, 2. Then re-request slots 0 and 2 with rr_ptr=0 → order 0, then 2. Exactly three acks in the first round.
- Overflow: req[1] twice while slot 1 is pending → overflow[1]=1; exactly one message transmitted; overflow[0] and overflow[2] remain 0.
- Length edges: len=0 → no data_send and no ack. len=12 → exactly 8 bytes, ending with msg[7:0].
- Reset mid-message: drop rst_n during GAP of byte 2 of 5 → data_send, busy, ack, overflow and tx_byte all 0 immediately. After release, no residual transmission and pending=0.
- Ack/req collision: issue req[0] in the DONE cycle of slot 0 → new message latched, no overflow, and it is transmitted after any other pending slot per rr_ptr.
